// File: rtl/xcfi_pkg.sv
// Shared types and default constants for the XCFI check scheduler.
package xcfi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StDone,
        StAbort
    } state_e;

    localparam int unsigned DefCntW    = 8;
    localparam int unsigned DefTimeout = 64;

endpackage

// File: rtl/xcfi_retire_select.sv
// Counts set retire strobes and finds the channel holding the rank-th (0-based) retirement.
module xcfi_retire_select #(
    parameter int unsigned NRET   = 1,
    parameter int unsigned RANK_W = 8,
    localparam int unsigned KW    = $clog2(NRET + 1),
    localparam int unsigned CHW   = (NRET > 1) ? $clog2(NRET) : 1
) (
    input  logic [NRET-1:0]   rvfi_valid,
    input  logic [RANK_W-1:0] rank,
    output logic [KW-1:0]     k,
    output logic              hit,
    output logic [CHW-1:0]    chan
);

    localparam int unsigned CmpW = RANK_W + KW;

    logic [KW-1:0] cnt;

    // Lowest channel index retires first, so walk upward.
    always_comb begin
        cnt  = '0;
        hit  = 1'b0;
        chan = '0;
        for (int i = 0; i < NRET; i++) begin
            if (rvfi_valid[i]) begin
                if (!hit && (CmpW'(cnt) == CmpW'(rank))) begin
                    hit  = 1'b1;
                    chan = CHW'(i);
                end
                cnt = cnt + KW'(1);
            end
        end
        k = cnt;
    end

endmodule

// File: rtl/xcfi_check_scheduler.sv
// Arms on start, counts retirements and strobes check on the target instruction's channel.
module xcfi_check_scheduler
    import xcfi_pkg::*;
#(
    parameter int unsigned NRET    = 1,
    parameter int unsigned CNT_W   = DefCntW,
    parameter int unsigned TIMEOUT = DefTimeout,
    localparam int unsigned CHW    = (NRET > 1) ? $clog2(NRET) : 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic [NRET-1:0]  rvfi_valid,
    input  logic [NRET-1:0]  rvfi_halt,
    output logic             check,
    output logic [CHW-1:0]   check_chan,
    output logic [CNT_W-1:0] retired_count,
    output logic             busy,
    output logic             done,
    output logic             abort
);

    localparam int unsigned KW = $clog2(NRET + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] rank;
    logic [KW-1:0]    k;
    logic             hit;
    logic [CHW-1:0]   chan;
    logic             armed, saturated, reachable;

    assign armed     = (state_q == StArmed);
    assign saturated = (count_q == CntMax);
    assign reachable = (target_q >= count_q);
    assign rank      = target_q - count_q;

    xcfi_retire_select #(
        .NRET   (NRET),
        .RANK_W (CNT_W)
    ) u_select (
        .rvfi_valid (rvfi_valid),
        .rank       (rank),
        .k          (k),
        .hit        (hit),
        .chan       (chan)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        timer_d  = timer_q;
        sum      = {1'b0, count_q} + (CNT_W + 1)'(k);
        // A saturated count no longer tracks the true index, so it may never match.
        check      = armed && reachable && !saturated && hit;
        check_chan = check ? chan : '0;
        unique case (state_q)
            StArmed: begin
                count_d = sum[CNT_W] ? CntMax : sum[CNT_W-1:0];
                timer_d = (|rvfi_valid) ? '0 : timer_q + TW'(1);
                if (check) begin
                    state_d = StDone;
                end else if ((|rvfi_halt) || (timer_d >= TW'(TIMEOUT))) begin
                    state_d = StAbort;
                end
            end
            default: begin
                if (start) begin
                    state_d  = StArmed;
                    target_d = target;
                    count_d  = '0;
                    timer_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            target_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
        end
    end

    assign retired_count = count_q;
    assign busy          = armed;
    assign done          = (state_q == StDone);
    assign abort         = (state_q == StAbort);

endmodule

// File: tb/tb_xcfi_check_scheduler.sv
// Directed bench for the check scheduler: two channels, 4-bit counter, timeout of 4.
module tb_xcfi_check_scheduler;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [3:0] target = '0;
    logic [1:0] rvfi_valid = '0;
    logic [1:0] rvfi_halt = '0;
    logic       check;
    logic [0:0] check_chan;
    logic [3:0] retired_count;
    logic       busy, done, abort;

    int n_checks = 0;
    int n_errors = 0;

    xcfi_check_scheduler #(
        .NRET    (2),
        .CNT_W   (4),
        .TIMEOUT (4)
    ) u_dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .target        (target),
        .rvfi_valid    (rvfi_valid),
        .rvfi_halt     (rvfi_halt),
        .check         (check),
        .check_chan    (check_chan),
        .retired_count (retired_count),
        .busy          (busy),
        .done          (done),
        .abort         (abort)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [3:0] t, input logic [1:0] v,
                         input logic [1:0] h);
        start      = s;
        target     = t;
        rvfi_valid = v;
        rvfi_halt  = h;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic arm(input logic [3:0] t);
        drive(1'b1, t, 2'b00, 2'b00);
        tick();
        start = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_check", check, 0);
        chk("rst_chan", check_chan, 0);
        chk("rst_count", retired_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_abort", abort, 0);
        resetn = 1'b1;
        tick();

        // One retirement per cycle, target 3: fires on the 4th.
        arm(4'd3);
        chk("a_busy", busy, 1);
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'd3, 2'b01, 2'b00);
            chk("a_check", check, (c == 3) ? 1 : 0);
            if (c == 3) chk("a_chan", check_chan, 0);
            tick();
        end
        drive(1'b0, 4'd0, 2'b00, 2'b00);
        chk("a_done", done, 1);
        chk("a_count", retired_count, 4);
        chk("a_check_off", check, 0);
        chk("a_busy_off", busy, 0);

        // Re-arm from DONE: 11 then 10, target 2 lands on channel 1.
        arm(4'd2);
        drive(1'b0, 4'd2, 2'b11, 2'b00);
        chk("b_check1", check, 0);
        tick();
        drive(1'b0, 4'd2, 2'b10, 2'b00);
        chk("b_check2", check, 1);
        chk("b_chan", check_chan, 1);
        tick();
        drive(1'b0, 4'd0, 2'b00, 2'b00);
        chk("b_count", retired_count, 3);
        chk("b_done", done, 1);

        // Halt with the 2nd retirement, target 5.
        arm(4'd5);
        drive(1'b0, 4'd5, 2'b01, 2'b00);
        tick();
        drive(1'b0, 4'd5, 2'b01, 2'b01);
        chk("c_check", check, 0);
        tick();
        drive(1'b0, 4'd0, 2'b00, 2'b00);
        chk("c_abort", abort, 1);
        chk("c_done", done, 0);

        // Timeout: one retirement then idle cycles.
        arm(4'd1);
        drive(1'b0, 4'd1, 2'b01, 2'b00);
        chk("d_check", check, 0);
        tick();
        drive(1'b0, 4'd1, 2'b00, 2'b00);
        tick();
        tick();
        tick();
        chk("d_busy3", busy, 1);
        chk("d_abort3", abort, 0);
        tick();
        chk("d_abort4", abort, 1);
        chk("d_count", retired_count, 1);

        // Halt coinciding with check resolves to DONE.
        arm(4'd0);
        drive(1'b0, 4'd0, 2'b01, 2'b01);
        chk("e_check", check, 1);
        tick();
        drive(1'b0, 4'd0, 2'b00, 2'b00);
        chk("e_done", done, 1);
        chk("e_abort", abort, 0);

        // start while ARMED is ignored; rank 1 of 11 selects channel 1.
        arm(4'd2);
        drive(1'b0, 4'd2, 2'b01, 2'b00);
        tick();
        drive(1'b1, 4'd0, 2'b00, 2'b00);
        tick();
        drive(1'b0, 4'd0, 2'b00, 2'b00);
        chk("f_count", retired_count, 1);
        chk("f_busy", busy, 1);
        drive(1'b0, 4'd0, 2'b11, 2'b00);
        chk("f_check", check, 1);
        chk("f_chan", check_chan, 1);
        tick();
        drive(1'b0, 4'd0, 2'b00, 2'b00);
        chk("f_final", retired_count, 3);

        // Async reset mid-arm discards it.
        arm(4'd3);
        drive(1'b0, 4'd3, 2'b01, 2'b00);
        tick();
        tick();
        drive(1'b0, 4'd3, 2'b00, 2'b00);
        chk("g_count2", retired_count, 2);
        resetn = 1'b0;
        drive(1'b0, 4'd3, 2'b01, 2'b00);
        chk("g_rst_count", retired_count, 0);
        chk("g_rst_busy", busy, 0);
        chk("g_rst_check", check, 0);
        chk("g_rst_done", done, 0);
        chk("g_rst_abort", abort, 0);
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'd0, 2'b11, 2'b00);
            chk("g_post_check", check, 0);
            tick();
        end
        chk("g_post_count", retired_count, 0);

        // start with a retirement in the same IDLE cycle, target 0.
        drive(1'b1, 4'd0, 2'b01, 2'b00);
        chk("h_idle_check", check, 0);
        tick();
        drive(1'b0, 4'd0, 2'b00, 2'b00);
        chk("h_count0", retired_count, 0);
        drive(1'b0, 4'd0, 2'b01, 2'b00);
        chk("h_check", check, 1);
        chk("h_chan", check_chan, 0);
        tick();
        drive(1'b0, 4'd0, 2'b00, 2'b00);
        chk("h_done", done, 1);
        chk("h_count1", retired_count, 1);

        // target at counter max: saturation must not fire check.
        arm(4'd15);
        for (int c = 0; c < 18; c++) begin
            drive(1'b0, 4'd15, (c < 15) ? 2'b01 : 2'b11, 2'b00);
            chk("i_check", check, 0);
            tick();
        end
        drive(1'b0, 4'd15, 2'b00, 2'b00);
        chk("i_count", retired_count, 15);
        chk("i_busy", busy, 1);
        drive(1'b0, 4'd15, 2'b00, 2'b10);
        tick();
        drive(1'b0, 4'd0, 2'b00, 2'b00);
        chk("i_abort", abort, 1);
        chk("i_done", done, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
